red_add_pipe: RTL and testbench
===============================

// Module: red_add_pipe
// PURPOSE
//  Parametrised, pipelined lane-reduction adder for the SIMD/RED datapath.
//  - Splits rs and rt into LANES lanes of LANE_W bits; returns the sum of all 2*LANES lanes, extended to OUT_W.
//  - Lanes are signed or unsigned per transaction.
//  - One adder-tree level per registered stage; valid/ready handshake on both sides.
//  - Full throughput of one transaction per clock when not back-pressured.
// PARAMETERS
//  LANE_W  4   bits per lane (>=2)
//  LANES   4   lanes per operand; power of 2, >=2
//  OUT_W   16  rd width; must be >= RES_W (derived: RES_W = LANE_W + log2(LANES) + 1)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              rs/rt/sgn valid
//  in_ready   out  1              block accepts when in_valid && in_ready
//  rs         in   LANES*LANE_W   operand A, lane i = rs[i*LANE_W +: LANE_W]
//  rt         in   LANES*LANE_W   operand B, same lane layout
//  sgn        in   1              1 = lanes two's-complement; 0 = unsigned
//  out_valid  out  1              rd valid
//  out_ready  in   1              consumer accepts when out_valid && out_ready
//  rd         out  OUT_W          reduced sum, sign- (sgn=1) or zero- (sgn=0) extended
//  acc_clr    in   1              [RED_ADD_ACCUM_EN only] clear accumulator
// BEHAVIOUR
//  - Stages: S = log2(LANES)+1.
//    - Stage 0 registers rs[i]+rt[i] per lane at LANE_W+1 bits.
//    - Stage k halves the partial-sum count; width grows by 1 bit per stage.
//    - Operands are extended per the sgn bit that travels with the data.
//  - Latency: transaction accepted at edge t -> out_valid=1 with its rd after edge t+S-1 (S cycles).
//  - Each stage has a valid bit. A stage loads when it is empty or its contents advance this cycle.
//    Last stage advances on out_ready.
//  - in_ready = !v[0] || stage 0 advancing (combinational).
//  - Stall: out_valid && !out_ready -> rd and out_valid held stable. Bubbles upstream still collapse.
//    Pipeline accepts until S entries are held, then in_ready=0.
//  - Simultaneous accept at input and drain at output in the same cycle is allowed; no loss, no duplication.
//  - Arithmetic is exact: RES_W holds the full range (unsigned max 2*LANES*(2^LANE_W-1), signed min -LANES*2^LANE_W).
//    No overflow is possible.
//  - Reset values: all stage valids 0, out_valid 0, rd 0, in_ready 1, accumulator 0.
//  - Reset asserted mid-operation discards every in-flight transaction immediately.
//    No output appears for them after release.
//  - Data registers need no reset except rd; out_valid gating is mandatory.
// CONFIGURATION
//  RED_ADD_ACCUM_EN defined:
//   - Adds port acc_clr and an OUT_W accumulator register.
//   - When a result enters the output register: acc <= (acc_clr ? 0 : acc) + ext(result), modulo 2^OUT_W.
//     rd = new acc value.
//   - acc_clr sampled with that result. acc_clr with no result entering -> acc <= 0, out_valid unaffected.
//  RED_ADD_ACCUM_EN undefined:
//   - No acc_clr port, no accumulator.
//   - rd = ext(result) of its own transaction.
// TESTING (LANE_W=4, LANES=4, OUT_W=16, S=3)
//  1. Reset: hold rst_n=0 -> out_valid=0, rd=0x0000, in_ready=1.
//     Release, idle 5 cycles -> out_valid stays 0.
//  2. Unsigned max: rs=rt=0xFFFF, sgn=0, out_ready=1 -> rd=0x0078 with out_valid after 3 cycles.
//     Signed: rs=rt=0xFFFF, sgn=1 -> 0xFFF8. rs=rt=0x8888, sgn=1 -> 0xFFC0. rs=rt=0x7777, sgn=1 -> 0x0038.
//  3. Throughput: 10 back-to-back random transactions, alternating sgn, out_ready=1.
//     -> 10 consecutive out_valid cycles, in order, each matching the reference model; in_ready never 0.
//  4. Backpressure: out_ready=0 for 6 cycles while driving in_valid.
//     -> exactly 3 accepted, in_ready=0 thereafter, rd stable.
//     Release out_ready -> 3 results drain in order, no loss.
//  5. Reset mid-flight: 2 transactions in pipeline, pulse rst_n low 1 cycle -> out_valid=0.
//     Neither result ever appears.
//  6. [RED_ADD_ACCUM_EN] rs=rt=0xFFFF, sgn=0 twice -> rd 0x0078 then 0x00F0.
//     Third with acc_clr=1 -> 0x0078. Sum past 0xFFFF wraps modulo 2^16.

Source files
------------

// File: rtl/red_add_pipe_if.sv
// Handshake bundle for red_add_pipe. acc_clr exists only when RED_ADD_ACCUM_EN is defined.
interface red_add_pipe_if #(
  parameter int unsigned LANE_W = 4,
  parameter int unsigned LANES  = 4,
  parameter int unsigned OUT_W  = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*LANE_W-1:0] rs;
  logic [LANES*LANE_W-1:0] rt;
  logic                    sgn;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        rd;
`ifdef RED_ADD_ACCUM_EN
  logic                    acc_clr;

  modport master (
    output in_valid, rs, rt, sgn, out_ready, acc_clr,
    input  in_ready, out_valid, rd
  );
  modport slave (
    input  in_valid, rs, rt, sgn, out_ready, acc_clr,
    output in_ready, out_valid, rd
  );
`else
  modport master (
    output in_valid, rs, rt, sgn, out_ready,
    input  in_ready, out_valid, rd
  );
  modport slave (
    input  in_valid, rs, rt, sgn, out_ready,
    output in_ready, out_valid, rd
  );
`endif
endinterface

// File: rtl/red_add_pipe.sv
// Pipelined lane-reduction adder: one adder-tree level per stage, valid/ready on both sides.
// Define RED_ADD_ACCUM_EN to add the acc_clr input and an OUT_W running accumulator on rd.
module red_add_pipe #(
  parameter int unsigned LANE_W = 4,
  parameter int unsigned LANES  = 4,
  parameter int unsigned OUT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  red_add_pipe_if.slave bus
);
  localparam int unsigned LogL  = $clog2(LANES);
  localparam int unsigned S     = LogL + 1;
  localparam int unsigned RES_W = LANE_W + LogL + 1;

  // Bit offset of stage k inside the flat bundle of all non-output stage registers.
  function automatic int unsigned stage_off(input int unsigned k);
    int unsigned o;
    o = 0;
    for (int unsigned m = 0; m < k; m++) o += (LANES >> m) * (LANE_W + 1 + m);
    return o;
  endfunction

  localparam int unsigned TotW    = stage_off(S - 1);
  localparam int unsigned LastOff = stage_off(S - 2);

  logic [S-1:0]     r_v;
  logic [S-1:0]     w_load;
  logic [S-1:0]     w_dload;
  logic [S-2:0]     r_sgn;
  logic [TotW-1:0]  w_flat;
  logic [OUT_W-1:0] r_rd;
  logic [OUT_W-1:0] w_res;

  // A stage may load when empty or when its contents move on this cycle.
  always_comb begin
    w_load      = '0;
    w_load[S-1] = !r_v[S-1] || bus.out_ready;
    for (int k = int'(S) - 2; k >= 0; k--) w_load[k] = !r_v[k] || w_load[k+1];
    w_dload    = '0;
    w_dload[0] = bus.in_valid && w_load[0];
    for (int k = 1; k < int'(S); k++) w_dload[k] = r_v[k-1] && w_load[k];
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_v[S-1];
  assign bus.rd        = r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      r_v <= (w_load & {r_v[S-2:0], bus.in_valid}) | (~w_load & r_v);
    end
  end

  always_ff @(posedge clk) begin
    if (w_dload[0]) r_sgn[0] <= bus.sgn;
    for (int k = 1; k < int'(S) - 1; k++) begin
      if (w_dload[k]) r_sgn[k] <= r_sgn[k-1];
    end
  end

  for (genvar k = 0; k < S - 1; k++) begin : g_stage
    localparam int unsigned W   = LANE_W + 1 + k;
    localparam int unsigned N   = LANES >> k;
    localparam int unsigned Off = stage_off(k);

    logic [N*W-1:0] w_sum;
    logic [N*W-1:0] r_sum;

    if (k == 0) begin : g_lane
      always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(N); i++) begin
          w_sum[i*W +: W] =
              {bus.sgn & bus.rs[i*LANE_W + LANE_W - 1], bus.rs[i*LANE_W +: LANE_W]} +
              {bus.sgn & bus.rt[i*LANE_W + LANE_W - 1], bus.rt[i*LANE_W +: LANE_W]};
        end
      end
    end else begin : g_tree
      localparam int unsigned PW   = W - 1;
      localparam int unsigned POff = stage_off(k - 1);
      always_comb begin
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        w_sum = '0;
        for (int i = 0; i < int'(N); i++) begin
          a = w_flat[POff + 2*i*PW +: PW];
          b = w_flat[POff + (2*i + 1)*PW +: PW];
          w_sum[i*W +: W] = {r_sgn[k-1] & a[PW-1], a} + {r_sgn[k-1] & b[PW-1], b};
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_dload[k]) r_sum <= w_sum;
    end

    assign w_flat[Off +: N*W] = r_sum;
  end

  logic [RES_W-2:0] w_p0;
  logic [RES_W-2:0] w_p1;
  logic [RES_W-1:0] w_last;

  assign w_p0   = w_flat[LastOff +: RES_W - 1];
  assign w_p1   = w_flat[LastOff + RES_W - 1 +: RES_W - 1];
  assign w_last = {r_sgn[S-2] & w_p0[RES_W-2], w_p0} + {r_sgn[S-2] & w_p1[RES_W-2], w_p1};
  assign w_res  = r_sgn[S-2] ? OUT_W'($signed(w_last)) : OUT_W'(w_last);

`ifdef RED_ADD_ACCUM_EN
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_acc_nxt;

  assign w_acc_nxt = (bus.acc_clr ? {OUT_W{1'b0}} : r_acc) + w_res;

  // acc_clr without an arriving result only clears; rd keeps its held value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rd  <= '0;
    end else if (w_dload[S-1]) begin
      r_acc <= w_acc_nxt;
      r_rd  <= w_acc_nxt;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
    end else if (w_dload[S-1]) begin
      r_rd <= w_res;
    end
  end
`endif
endmodule

// File: tb/tb_red_add_pipe.sv
// Directed self-checking bench for red_add_pipe (LANE_W=4, LANES=4, OUT_W=16, three stages).
module tb_red_add_pipe;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned LANES  = 4;
  localparam int unsigned OUT_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  red_add_pipe_if #(.LANE_W(LANE_W), .LANES(LANES), .OUT_W(OUT_W)) bus ();

  red_add_pipe #(.LANE_W(LANE_W), .LANES(LANES), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ar_rs  [4] = '{16'hFFFF, 16'hFFFF, 16'h8888, 16'h7777};
  logic        ar_sgn [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] ar_exp [4] = '{16'h0078, 16'hFFF8, 16'hFFC0, 16'h0038};

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    int          acc;
    logic [3:0]  la;
    logic [3:0]  lb;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      la = a[i*4 +: 4];
      lb = b[i*4 +: 4];
      if (s) acc += int'($signed(la)) + int'($signed(lb));
      else   acc += int'(la) + int'(lb);
    end
    return acc[15:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.rd !== 16'h0000) begin
      n_err++; $display("FAIL reset_rd: got %h expected 0000", bus.rd);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL idle_out_valid[%0d]: got %b expected 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_arith();
    bus.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.rs       = ar_rs[v];
      bus.rt       = ar_rs[v];
      bus.sgn      = ar_sgn[v];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL arith_early1[%0d]: got %b expected 0", v, bus.out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL arith_early2[%0d]: got %b expected 0", v, bus.out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL arith_valid[%0d]: got %b expected 1", v, bus.out_valid);
      end
      n_cmp++;
      if (bus.rd !== ar_exp[v]) begin
        n_err++; $display("FAIL arith_rd[%0d]: got %h expected %h", v, bus.rd, ar_exp[v]);
      end
    end
  endtask

  task automatic test_throughput();
    logic [15:0] q[$];
    logic [15:0] exp_v;
    int          n_out;
    int          last_c;
    bit          contig;
    n_out  = 0;
    last_c = 0;
    contig = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c < 10) begin
        bus.in_valid = 1'b1;
        bus.rs       = 16'($urandom);
        bus.rt       = 16'($urandom);
        bus.sgn      = c[0];
        q.push_back(ref_sum(bus.rs, bus.rt, bus.sgn));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 10) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_err++; $display("FAIL tput_in_ready[%0d]: got %b expected 1", c, bus.in_ready);
        end
      end
      if (bus.out_valid === 1'b1) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        n_cmp++;
        if (bus.rd !== exp_v) begin
          n_err++; $display("FAIL tput_rd[%0d]: got %h expected %h", n_out, bus.rd, exp_v);
        end
        if (n_out > 0 && c != last_c + 1) contig = 1'b0;
        last_c = c;
        n_out++;
      end
    end
    n_cmp++;
    if (n_out != 10 || !contig) begin
      n_err++;
      $display("FAIL tput_count: got %0d results contiguous=%0d expected 10 contiguous=1",
               n_out, contig);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q[$];
    logic [15:0] held;
    logic [15:0] exp_v;
    bit          have;
    int          idx;
    int          n_got;
    have = 1'b0;
    idx  = 0;
    held = '0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.rs       = {4{4'(idx + 9)}};
      bus.rt       = 16'h3A5C;
      bus.sgn      = idx[0];
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        q.push_back(ref_sum(bus.rs, bus.rt, bus.sgn));
        idx++;
      end
      if (bus.out_valid === 1'b1) begin
        if (!have) begin
          held = bus.rd;
          have = 1'b1;
          n_cmp++;
          if (bus.rd !== q[0]) begin
            n_err++; $display("FAIL bp_first_rd: got %h expected %h", bus.rd, q[0]);
          end
        end else begin
          n_cmp++;
          if (bus.rd !== held) begin
            n_err++; $display("FAIL bp_rd_stable[%0d]: got %h expected %h", c, bus.rd, held);
          end
        end
      end
    end
    n_cmp++;
    if (idx != 3) begin
      n_err++; $display("FAIL bp_accepted: got %0d expected 3", idx);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        n_cmp++;
        if (bus.rd !== exp_v) begin
          n_err++; $display("FAIL bp_drain_rd[%0d]: got %h expected %h", n_got, bus.rd, exp_v);
        end
        n_got++;
      end
    end
    n_cmp++;
    if (n_got != 3) begin
      n_err++; $display("FAIL bp_drain_count: got %0d expected 3", n_got);
    end
  endtask

  task automatic test_reset_midflight();
    int n_seen;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.rs       = 16'h1234;
    bus.rt       = 16'h4321;
    bus.sgn      = 1'b0;
    @(posedge clk); #1;
    bus.rs       = 16'hFFFF;
    bus.rt       = 16'h0001;
    bus.sgn      = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) n_seen++;
    end
    n_cmp++;
    if (n_seen != 0) begin
      n_err++; $display("FAIL midrst_ghosts: got %0d results expected 0", n_seen);
    end
  endtask

`ifdef RED_ADD_ACCUM_EN
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic clr, output logic [15:0] rd_o, output bit ok);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.rs       = a;
    bus.rt       = b;
    bus.sgn      = s;
    bus.acc_clr  = clr;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ok   = 1'b0;
    rd_o = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        rd_o = bus.rd;
        ok   = 1'b1;
        break;
      end
    end
    bus.acc_clr = 1'b0;
  endtask

  task automatic test_accum();
    logic [15:0] a_rs  [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8888};
    logic        a_sgn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        a_clr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] a_exp [4] = '{16'h0078, 16'h00F0, 16'h0078, 16'h0038};
    logic [15:0] got;
    bit          ok;
    bus.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      run_one(a_rs[v], a_rs[v], a_sgn[v], a_clr[v], got, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL accum_timeout[%0d]: got no result expected one", v);
      end else if (got !== a_exp[v]) begin
        n_err++; $display("FAIL accum_rd[%0d]: got %h expected %h", v, got, a_exp[v]);
      end
    end
    bus.acc_clr = 1'b1;
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.rs        = '0;
    bus.rt        = '0;
    bus.sgn       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef RED_ADD_ACCUM_EN
    bus.acc_clr   = 1'b1;
`endif
    test_reset();
    test_arith();
    test_throughput();
    test_backpressure();
    test_reset_midflight();
`ifdef RED_ADD_ACCUM_EN
    test_accum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
